// File: rtl/sht40_pkg.sv
// Shared definitions for the SHT40 raw-to-engineering-units conversion path.
// Contents:
//   conv_state_e  - converter FSM encoding (IDLE/LOAD/MUL/FIN)
//   chan_e        - which channel occupies the shared multiplier
//   *_DEF         - default scale/offset constants (centi-units)
//   RH_MAX        - upper humidity clamp in centi-%RH
//   MUL_CYCLES    - shift-add steps per multiply (one per multiplier bit)
//   sat_add8      - saturating 8-bit add used by the drop counter
package sht40_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StMul  = 2'd2,
        StFin  = 2'd3
    } conv_state_e;

    typedef enum logic {
        ChTemp = 1'b0,
        ChRh   = 1'b1
    } chan_e;

    localparam int unsigned T_SCALE_DEF   = 17500;
    localparam int unsigned T_OFFSET_DEF  = 4500;
    localparam int unsigned RH_SCALE_DEF  = 12500;
    localparam int unsigned RH_OFFSET_DEF = 600;
    localparam int unsigned RH_MAX        = 10000;
    localparam int unsigned MUL_CYCLES    = 16;

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {7'd0, b};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/sht40_serial_mult.sv
// 16x15 unsigned LSB-first shift-add multiplier, one multiplier bit per cycle.
// Ports:
//   clk        - system clock
//   rst_ni     - synchronous active-low reset; abandons any multiply in flight
//   start_i    - load operands and clear the accumulator (one cycle)
//   a_i        - 16-bit multiplier (bits consumed LSB first)
//   b_i        - 15-bit multiplicand
//   done_o     - high during the final step; product_o is complete the next cycle
//   product_o  - 31-bit accumulator / product
module sht40_serial_mult
    import sht40_pkg::*;
(
    input  logic        clk,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [15:0] a_i,
    input  logic [14:0] b_i,
    output logic        done_o,
    output logic [30:0] product_o
);

    logic [15:0] a_q;
    logic [30:0] b_q;
    logic [30:0] acc_q;
    logic [3:0]  cnt_q;
    logic        run_q;

    // Combinational so the parent can leave MUL on the same edge as the last step.
    assign done_o    = run_q && (cnt_q == 4'(MUL_CYCLES - 1));
    assign product_o = acc_q;

    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start_i) begin
            a_q   <= a_i;
            b_q   <= {16'd0, b_i};
            acc_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b1;
        end else if (run_q) begin
            if (a_q[0]) begin
                acc_q <= acc_q + b_q;
            end
            a_q   <= a_q >> 1;
            b_q   <= b_q << 1;
            cnt_q <= cnt_q + 4'd1;
            if (done_o) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sht40_convert.sv
// Converts raw SHT40 temperature/humidity words into centi-degC (signed) and
// centi-%RH (unsigned) using one shared serial multiplier, temperature first.
// Ports:
//   clk, Reset_N          - clock, synchronous active-low reset
//   Temperature_Input     - raw temperature word
//   Humidity_Input        - raw humidity word
//   Temp_Ready, RH_Ready  - word-ready strobes (rising edge captures)
//   CRC_Error             - when high on a ready edge the word is dropped
//   Temp_Centi, RH_Centi  - converted results, held until next update
//   Temp_Valid, RH_Valid  - one-cycle update pulses
//   Busy                  - FSM not idle
//   Overrun_Error         - sticky: pending word overwritten before use
//   Drop_Count            - saturating count of CRC-dropped words
module sht40_convert
    import sht40_pkg::*;
#(
    parameter int unsigned T_SCALE   = T_SCALE_DEF,
    parameter int unsigned T_OFFSET  = T_OFFSET_DEF,
    parameter int unsigned RH_SCALE  = RH_SCALE_DEF,
    parameter int unsigned RH_OFFSET = RH_OFFSET_DEF,
    parameter bit          RH_CLAMP  = 1'b1
) (
    input  logic        clk,
    input  logic        Reset_N,
    input  logic [15:0] Temperature_Input,
    input  logic [15:0] Humidity_Input,
    input  logic        Temp_Ready,
    input  logic        RH_Ready,
    input  logic        CRC_Error,
    output logic [15:0] Temp_Centi,
    output logic [15:0] RH_Centi,
    output logic        Temp_Valid,
    output logic        RH_Valid,
    output logic        Busy,
    output logic        Overrun_Error,
    output logic [7:0]  Drop_Count
);

    localparam logic [14:0] TScale  = 15'(T_SCALE);
    localparam logic [14:0] RhScale = 15'(RH_SCALE);
    localparam logic [16:0] TOff    = 17'(T_OFFSET);
    localparam logic [16:0] RhOff   = 17'(RH_OFFSET);
    localparam logic [16:0] RhMax17 = 17'(RH_MAX);

    conv_state_e state_q, state_d;
    chan_e       ch_q, ch_d;

    logic        t_prev_q, rh_prev_q;
    logic [15:0] t_hold_q, rh_hold_q;
    logic        t_pend_q, t_pend_d;
    logic        rh_pend_q, rh_pend_d;
    logic        overrun_q, overrun_d;
    logic [7:0]  drop_q, drop_d;
    logic [15:0] temp_q, temp_d;
    logic [15:0] rh_q, rh_d;
    logic        tv_q, tv_d;
    logic        rv_q, rv_d;

    logic        t_edge, rh_edge, t_cap, rh_cap, t_any, rh_any, dispatch;
    logic        mult_start, mult_done;
    logic [15:0] mult_a;
    logic [14:0] mult_b;
    logic [30:0] product;
    logic [14:0] q;
    logic [16:0] res;
    logic [15:0] rh_res;

    assign t_edge  = Temp_Ready & ~t_prev_q;
    assign rh_edge = RH_Ready & ~rh_prev_q;
    assign t_cap   = t_edge & ~CRC_Error;
    assign rh_cap  = rh_edge & ~CRC_Error;
    // A word captured this cycle can be dispatched on the same edge, which is
    // what gives the 19-cycle edge-to-valid latency.
    assign t_any   = t_pend_q | t_cap;
    assign rh_any  = rh_pend_q | rh_cap;

    assign mult_a = (ch_q == ChTemp) ? t_hold_q : rh_hold_q;
    assign mult_b = (ch_q == ChTemp) ? TScale : RhScale;

    sht40_serial_mult u_mult (
        .clk       (clk),
        .rst_ni    (Reset_N),
        .start_i   (mult_start),
        .a_i       (mult_a),
        .b_i       (mult_b),
        .done_o    (mult_done),
        .product_o (product)
    );

    // Scale result: truncating divide by 65536, then remove the offset.
    always_comb begin
        q   = product[30:16];
        res = {2'b00, q} - ((ch_q == ChTemp) ? TOff : RhOff);
        rh_res = res[15:0];
        if (RH_CLAMP) begin
            if (res[16]) begin
                rh_res = '0;
            end else if (res > RhMax17) begin
                rh_res = RhMax17[15:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        mult_start = 1'b0;
        dispatch   = 1'b0;
        t_pend_d   = t_any;
        rh_pend_d  = rh_any;
        temp_d     = temp_q;
        rh_d       = rh_q;
        tv_d       = 1'b0;
        rv_d       = 1'b0;
        overrun_d  = overrun_q | (t_cap & t_pend_q) | (rh_cap & rh_pend_q);
        drop_d     = sat_add8(drop_q, {1'b0, t_edge & CRC_Error} + {1'b0, rh_edge & CRC_Error});

        unique case (state_q)
            StIdle: begin
                dispatch = 1'b1;
            end
            StLoad: begin
                mult_start = 1'b1;
                state_d    = StMul;
            end
            StMul: begin
                if (mult_done) begin
                    state_d = StFin;
                end
            end
            StFin: begin
                if (ch_q == ChTemp) begin
                    temp_d = res[15:0];
                    tv_d   = 1'b1;
                end else begin
                    rh_d = rh_res;
                    rv_d = 1'b1;
                end
                state_d  = StIdle;
                dispatch = 1'b1;
            end
            default: state_d = StIdle;
        endcase

        if (dispatch) begin
            if (t_any) begin
                state_d  = StLoad;
                ch_d     = ChTemp;
                t_pend_d = 1'b0;
            end else if (rh_any) begin
                state_d   = StLoad;
                ch_d      = ChRh;
                rh_pend_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!Reset_N) begin
            state_q   <= StIdle;
            ch_q      <= ChTemp;
            t_prev_q  <= 1'b0;
            rh_prev_q <= 1'b0;
            t_hold_q  <= '0;
            rh_hold_q <= '0;
            t_pend_q  <= 1'b0;
            rh_pend_q <= 1'b0;
            overrun_q <= 1'b0;
            drop_q    <= '0;
            temp_q    <= '0;
            rh_q      <= '0;
            tv_q      <= 1'b0;
            rv_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            t_prev_q  <= Temp_Ready;
            rh_prev_q <= RH_Ready;
            if (t_cap) begin
                t_hold_q <= Temperature_Input;
            end
            if (rh_cap) begin
                rh_hold_q <= Humidity_Input;
            end
            t_pend_q  <= t_pend_d;
            rh_pend_q <= rh_pend_d;
            overrun_q <= overrun_d;
            drop_q    <= drop_d;
            temp_q    <= temp_d;
            rh_q      <= rh_d;
            tv_q      <= tv_d;
            rv_q      <= rv_d;
        end
    end

    assign Temp_Centi    = temp_q;
    assign RH_Centi      = rh_q;
    assign Temp_Valid    = tv_q;
    assign RH_Valid      = rv_q;
    assign Busy          = (state_q != StIdle);
    assign Overrun_Error = overrun_q;
    assign Drop_Count    = drop_q;

endmodule

// File: tb/tb_sht40_convert.sv
// Bench for sht40_convert: vector table plus hand-built multi-cycle sequences,
// with per-channel scoreboards checked whenever a valid pulse appears.
module tb_sht40_convert;

    logic        clk = 1'b0;
    logic        Reset_N;
    logic [15:0] Temperature_Input, Humidity_Input;
    logic        Temp_Ready, RH_Ready, CRC_Error;
    logic [15:0] Temp_Centi, RH_Centi;
    logic        Temp_Valid, RH_Valid, Busy, Overrun_Error;
    logic [7:0]  Drop_Count;

    always #5 clk = ~clk;

    sht40_convert dut (
        .clk               (clk),
        .Reset_N           (Reset_N),
        .Temperature_Input (Temperature_Input),
        .Humidity_Input    (Humidity_Input),
        .Temp_Ready        (Temp_Ready),
        .RH_Ready          (RH_Ready),
        .CRC_Error         (CRC_Error),
        .Temp_Centi        (Temp_Centi),
        .RH_Centi          (RH_Centi),
        .Temp_Valid        (Temp_Valid),
        .RH_Valid          (RH_Valid),
        .Busy              (Busy),
        .Overrun_Error     (Overrun_Error),
        .Drop_Count        (Drop_Count)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] val;
        int          at;
    } exp_t;

    exp_t qt[$];
    exp_t qr[$];

    typedef struct {
        bit          rh;
        logic [15:0] raw;
        logic [15:0] expv;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, expv, expv);
        end
    endtask

    // Scoreboard: every valid pulse must match the oldest expectation of its channel.
    exp_t et, er;
    always @(negedge clk) begin
        if (Temp_Valid) begin
            if (qt.size() == 0) begin
                check("temp_valid_unexpected", 32'd1, 32'd0);
            end else begin
                et = qt.pop_front();
                check("temp_value", {16'd0, Temp_Centi}, {16'd0, et.val});
                check("temp_latency", 32'(cyc), 32'(et.at));
            end
        end
        if (RH_Valid) begin
            if (qr.size() == 0) begin
                check("rh_valid_unexpected", 32'd1, 32'd0);
            end else begin
                er = qr.pop_front();
                check("rh_value", {16'd0, RH_Centi}, {16'd0, er.val});
                check("rh_latency", 32'(cyc), 32'(er.at));
            end
        end
    end

    // One-cycle ready pulse; lat > 0 queues an expected result lat cycles later.
    task automatic pulse(input bit rh, input logic [15:0] raw, input bit crc,
                         input logic [15:0] expv, input int lat);
        exp_t e;
        @(posedge clk); #1;
        if (rh) begin
            Humidity_Input = raw;
            RH_Ready       = 1'b1;
        end else begin
            Temperature_Input = raw;
            Temp_Ready        = 1'b1;
        end
        CRC_Error = crc;
        if (lat > 0) begin
            e.val = expv;
            e.at  = cyc + lat;
            if (rh) qr.push_back(e);
            else    qt.push_back(e);
        end
        @(posedge clk); #1;
        Temp_Ready = 1'b0;
        RH_Ready   = 1'b0;
        CRC_Error  = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 80; i++) begin
            if (qt.size() == 0 && qr.size() == 0) break;
            @(posedge clk);
        end
        check(name, 32'(qt.size() + qr.size()), 32'd0);
        repeat (2) @(posedge clk);
    endtask

    vec_t vecs[8];

    initial begin
        exp_t e;
        int   c;
        bit   busy_ok;

        vecs[0] = '{rh: 1'b0, raw: 16'h6666, expv: 16'd2499};
        vecs[1] = '{rh: 1'b0, raw: 16'h0000, expv: 16'hEE6C};
        vecs[2] = '{rh: 1'b0, raw: 16'hFFFF, expv: 16'd12999};
        vecs[3] = '{rh: 1'b0, raw: 16'h8000, expv: 16'd4250};
        vecs[4] = '{rh: 1'b1, raw: 16'h8000, expv: 16'd5650};
        vecs[5] = '{rh: 1'b1, raw: 16'h0000, expv: 16'd0};
        vecs[6] = '{rh: 1'b1, raw: 16'hFFFF, expv: 16'd10000};
        vecs[7] = '{rh: 1'b1, raw: 16'h4000, expv: 16'd2525};

        Reset_N           = 1'b0;
        Temp_Ready        = 1'b0;
        RH_Ready          = 1'b0;
        CRC_Error         = 1'b0;
        Temperature_Input = '0;
        Humidity_Input    = '0;
        repeat (3) @(posedge clk);
        #1 Reset_N = 1'b1;

        check("rst_temp_centi", {16'd0, Temp_Centi}, 32'd0);
        check("rst_rh_centi", {16'd0, RH_Centi}, 32'd0);
        check("rst_valids", {30'd0, Temp_Valid, RH_Valid}, 32'd0);
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_overrun", {31'd0, Overrun_Error}, 32'd0);
        check("rst_drop", {24'd0, Drop_Count}, 32'd0);

        foreach (vecs[i]) begin
            pulse(vecs[i].rh, vecs[i].raw, 1'b0, vecs[i].expv, 19);
            drain("vec_drain");
        end

        // Simultaneous edges: temperature first, RH one conversion later.
        @(posedge clk); #1;
        Temperature_Input = 16'h6666;
        Humidity_Input    = 16'h8000;
        Temp_Ready        = 1'b1;
        RH_Ready          = 1'b1;
        c = cyc;
        e.val = 16'd2499; e.at = c + 19; qt.push_back(e);
        e.val = 16'd5650; e.at = c + 37; qr.push_back(e);
        busy_ok = 1'b1;
        for (int k = 0; k < 38; k++) begin
            @(negedge clk);
            if (Busy !== ((cyc >= c + 1) && (cyc <= c + 36))) busy_ok = 1'b0;
        end
        Temp_Ready = 1'b0;
        RH_Ready   = 1'b0;
        check("both_busy_window", {31'd0, busy_ok}, 32'd1);
        drain("both_drain");

        // CRC-flagged words are dropped and counted, saturating at 255.
        pulse(1'b0, 16'h6666, 1'b1, 16'd0, 0);
        check("drop_first", {24'd0, Drop_Count}, 32'd1);
        repeat (25) @(posedge clk);
        check("drop_no_busy", {31'd0, Busy}, 32'd0);
        for (int k = 0; k < 299; k++) pulse(1'b0, 16'h1234, 1'b1, 16'd0, 0);
        check("drop_saturate", {24'd0, Drop_Count}, 32'd255);

        // Two temperature words during an RH conversion: latest wins, overrun sticks.
        check("overrun_before", {31'd0, Overrun_Error}, 32'd0);
        pulse(1'b1, 16'h4000, 1'b0, 16'd2525, 19);
        pulse(1'b0, 16'h1000, 1'b0, 16'd0, 0);
        pulse(1'b0, 16'h6666, 1'b0, 16'd2499, 33);
        drain("overrun_drain");
        check("overrun_set", {31'd0, Overrun_Error}, 32'd1);
        repeat (10) @(posedge clk);
        check("overrun_sticky", {31'd0, Overrun_Error}, 32'd1);

        // Reset mid-multiply discards the conversion.
        pulse(1'b0, 16'h6666, 1'b0, 16'd0, 0);
        repeat (5) @(posedge clk);
        #1 Reset_N = 1'b0;
        @(posedge clk); #1;
        Reset_N = 1'b1;
        check("mid_rst_busy", {31'd0, Busy}, 32'd0);
        check("mid_rst_temp", {16'd0, Temp_Centi}, 32'd0);
        check("mid_rst_rh", {16'd0, RH_Centi}, 32'd0);
        check("mid_rst_overrun", {31'd0, Overrun_Error}, 32'd0);
        check("mid_rst_drop", {24'd0, Drop_Count}, 32'd0);
        repeat (25) @(posedge clk);
        pulse(1'b0, 16'hFFFF, 1'b0, 16'd12999, 19);
        drain("post_rst_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
